// File: rtl/fpu_scoreboard.sv
// Issue/scoreboard controller for one multi-cycle FPU op: start pulse, per-op latency count, pending-rd hazard stall.
// Result is presented on wb_valid L cycles after fpu_start and held until wb_grant; ID is stalled while busy or hazarded.
module fpu_scoreboard #(
    parameter int             REGFILE_LEN     = 6,
    parameter int             FPU_OP_WIDTH    = 5,
    parameter int             LAT_WIDTH       = 4,
    parameter int             DEFAULT_LATENCY = 3,
    parameter int             FDIV_LATENCY    = 12,
    parameter int             FSQRT_LATENCY   = 15,
    parameter [FPU_OP_WIDTH-1:0] FDIV_OP      = 5'b00011,
    parameter [FPU_OP_WIDTH-1:0] FSQRT_OP     = 5'b01011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic                    id_alu_fpu,
    input  logic [FPU_OP_WIDTH-1:0] id_fpu_op,
    input  logic [REGFILE_LEN-1:0]  id_rs1,
    input  logic [REGFILE_LEN-1:0]  id_rs2,
    input  logic [REGFILE_LEN-1:0]  id_rd,
    input  logic                    id_reg_write,
    input  logic                    flush,
    input  logic                    wb_grant,
    output logic                    stall,
    output logic                    fpu_start,
    output logic                    busy,
    output logic                    wb_valid,
    output logic [REGFILE_LEN-1:0]  wb_rd
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [LAT_WIDTH-1:0] LAT_DEF_M1   = LAT_WIDTH'(DEFAULT_LATENCY - 1);
    localparam logic [LAT_WIDTH-1:0] LAT_FDIV_M1  = LAT_WIDTH'(FDIV_LATENCY - 1);
    localparam logic [LAT_WIDTH-1:0] LAT_FSQRT_M1 = LAT_WIDTH'(FSQRT_LATENCY - 1);
    localparam logic [LAT_WIDTH-1:0] CNT_ONE      = LAT_WIDTH'(1);

    state_t                   r_state;
    logic [LAT_WIDTH-1:0]     r_cnt;
    logic [REGFILE_LEN-1:0]   r_pend_rd;
    logic                     r_pend_we;

    logic                     w_hit_rs1;
    logic                     w_hit_rs2;
    logic                     w_hit_rd;
    logic                     w_hazard;
    logic                     w_free;
    logic                     w_issue;
    logic [LAT_WIDTH-1:0]     w_lat_m1;

    // x0 is hardwired, so it never creates a dependency on the pending destination.
    assign w_hit_rs1 = r_pend_we && (id_rs1 == r_pend_rd) && (id_rs1 != '0) && (r_state != IDLE);
    assign w_hit_rs2 = r_pend_we && (id_rs2 == r_pend_rd) && (id_rs2 != '0) && (r_state != IDLE);
    assign w_hit_rd  = r_pend_we && (id_rd  == r_pend_rd) && (id_rd  != '0) && (r_state != IDLE);

    // Hazard uses the current pend_rd even in the grant cycle: dependents issue after the regfile write lands.
    assign w_hazard  = w_hit_rs1 || w_hit_rs2 || (id_reg_write && w_hit_rd);
    assign w_free    = (r_state == IDLE) || ((r_state == DONE) && wb_grant);
    assign w_issue   = id_valid && id_alu_fpu && !flush && w_free && !w_hazard;

    assign fpu_start = w_issue;
    assign stall     = id_valid && !flush && (w_hazard || (id_alu_fpu && !w_free));
    assign busy      = (r_state != IDLE);
    assign wb_valid  = (r_state == DONE);
    assign wb_rd     = r_pend_rd;

    always_comb begin
        w_lat_m1 = LAT_DEF_M1;
        if (id_fpu_op == FDIV_OP)
            w_lat_m1 = LAT_FDIV_M1;
        else if (id_fpu_op == FSQRT_OP)
            w_lat_m1 = LAT_FSQRT_M1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pend_rd <= '0;
            r_pend_we <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_cnt     <= w_lat_m1;
                        r_pend_rd <= id_rd;
                        r_pend_we <= id_reg_write;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_ONE)
                        r_state <= DONE;
                    else
                        r_cnt <= r_cnt - CNT_ONE;
                end
                DONE: begin
                    if (wb_grant) begin
                        if (w_issue) begin
                            r_cnt     <= w_lat_m1;
                            r_pend_rd <= id_rd;
                            r_pend_we <= id_reg_write;
                            r_state   <= BUSY;
                        end else begin
                            r_pend_we <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
